tx_axis_arbiter: RTL and testbench
==================================

Name: tx_axis_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single AXI-Stream input of the 10G TX MAC between NUM_SRC independent frame sources (e.g. user data path, pause-frame generator, management path).
- Grants one source per frame, locks the grant until that frame's tlast is accepted, then rotates priority.
- Sits directly upstream of the TX MAC; the MAC's s_axis_trdy is the only backpressure into this block.

Parameters:
- NUM_SRC, 2, number of upstream AXI-Stream sources (2..8).
- DATA_WIDTH, 32, tdata width per source; matches the MAC XGMII data width.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width per source.
- IDX_WIDTH, $clog2(NUM_SRC) (min 1), width of the grant index.
- CNT_WIDTH, 16, width of the per-source frame counters.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_SRC*KEEP_WIDTH  source byte enables, packed the same way.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source end of frame.
- s_axis_trdy  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  DATA_WIDTH  to MAC.
- m_axis_tkeep  out  KEEP_WIDTH  to MAC.
- m_axis_tvalid  out  1  to MAC.
- m_axis_tlast  out  1  to MAC.
- m_axis_trdy  in  1  from MAC.
- o_grant_idx  out  IDX_WIDTH  index of the currently or last granted source.
- o_busy  out  1  high while a frame is locked (XFER state).
- o_frame_cnt  out  NUM_SRC*CNT_WIDTH  per-source count of completed frames.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant_idx=0, rr_ptr=0 (source 0 has highest priority), all s_axis_trdy=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep=0, o_busy=0, all frame counters=0.
- Reset asserted mid-frame: outputs drop immediately (asynchronously); the partial frame is abandoned with no recovery.
- States: IDLE, XFER.
- IDLE:
  - Search s_axis_tvalid starting at rr_ptr and wrapping modulo NUM_SRC; the first asserted source k wins.
  - On the next edge: grant_idx<=k, state<=XFER.
  - No data is passed in IDLE; m_axis_tvalid=0 and all trdy=0.
- XFER (combinational mux on the registered grant):
  - m_axis_{tdata,tkeep,tlast,tvalid} = source grant_idx fields.
  - s_axis_trdy[grant_idx] = m_axis_trdy; all other trdy=0.
  - o_busy=1.
- Frame end: on an edge with m_axis_tvalid & m_axis_trdy & m_axis_tlast:
  - state<=IDLE;
  - rr_ptr<=(grant_idx+1) mod NUM_SRC;
  - frame_cnt[grant_idx] increments, saturating at all-ones.
- Latency:
  - tvalid seen in IDLE at edge N gives grant at N+1; the first beat is presented to the MAC during cycle N+1.
  - Each frame therefore costs exactly one IDLE cycle of arbitration overhead. This bubble is acceptable because the MAC already inserts preamble and IFG.
- Grant lock: the grant never changes in XFER.
  - If the granted source drops tvalid mid-frame, m_axis_tvalid follows it low and the arbiter waits; other sources stay blocked.
  - m_axis_trdy low stalls the transfer; the lock is held.
- Simultaneous requests: resolved solely by rr_ptr order. A source that just finished has lowest priority in the next arbitration.
- Single-beat frame (tvalid & tlast on the first beat): legal. It completes in one XFER cycle if m_axis_trdy=1.
- Counter wrap: saturate, never wrap.
- NUM_SRC=1 degenerates to a pass-through that still has the one-cycle IDLE bubble per frame.

Test Plan:
- Reset then idle: all tvalid=0 for 20 cycles -> state IDLE, m_axis_tvalid=0, s_axis_trdy=0, o_grant_idx=0, counters 0.
- Single source: src1 sends a 16-beat frame, m_axis_trdy=1 -> grant_idx=1 one cycle after tvalid; 16 beats pass bit-exact with tkeep; frame_cnt[1]=1; rr_ptr=0.
- Contention: src0 and src1 both continuously hold 4-beat frames -> grants alternate 0,1,0,1 for 8 frames; each frame_cnt=4; no beat interleaving.
- Backpressure: m_axis_trdy toggled 1,0,1,0 during a 15-beat frame from src0 -> src1 stays trdy=0 throughout; 15 beats delivered in order; lock held until tlast is accepted.
- Mid-frame source gap: src0 drops tvalid for 3 cycles at beat 5 while src1 is requesting -> m_axis_tvalid=0 for those 3 cycles; grant stays 0; src1 is granted only after src0's tlast.
- Async reset at beat 7 of a frame -> m_axis_tvalid and all trdy go to 0 before the next edge; after release, a new frame from src1 is granted cleanly and counters restart at 0.

Source files
------------

// File: rtl/tx_axis_arbiter.sv
// Packet-level round-robin arbiter sharing the TX MAC AXI-Stream input between NUM_SRC sources.
// One source is granted per frame and held until its tlast is accepted.
module tx_axis_arbiter #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned IDX_WIDTH  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_SRC*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [NUM_SRC-1:0]              s_axis_tvalid,
  input  logic [NUM_SRC-1:0]              s_axis_tlast,
  output logic [NUM_SRC-1:0]              s_axis_trdy,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_trdy,
  output logic [IDX_WIDTH-1:0]            o_grant_idx,
  output logic                            o_busy,
  output logic [NUM_SRC*CNT_WIDTH-1:0]    o_frame_cnt
);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]   frame_cnt_q [NUM_SRC];
  logic [CNT_WIDTH-1:0]   frame_cnt_d [NUM_SRC];

  logic                   req_found;
  logic [IDX_WIDTH-1:0]   req_idx;
  logic [IDX_WIDTH-1:0]   cand;
  logic                   frame_done;

  function automatic logic [IDX_WIDTH-1:0] wrap_idx(input int unsigned v);
    return IDX_WIDTH'(v % NUM_SRC);
  endfunction

  // Round-robin search starting at rr_ptr; first requester in wrap order wins.
  always_comb begin
    req_found = 1'b0;
    req_idx   = rr_ptr_q;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = wrap_idx(32'(rr_ptr_q) + i);
      if (!req_found && s_axis_tvalid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  // Data path is a pure mux on the registered grant, so reset clears it asynchronously.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_trdy   = '0;
    if (state_q == StXfer) begin
      m_axis_tdata         = s_axis_tdata[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep         = s_axis_tkeep[32'(grant_q) * KEEP_WIDTH +: KEEP_WIDTH];
      m_axis_tvalid        = s_axis_tvalid[grant_q];
      m_axis_tlast         = s_axis_tlast[grant_q];
      s_axis_trdy[grant_q] = m_axis_trdy;
    end
  end

  assign frame_done = (state_q == StXfer) && m_axis_tvalid && m_axis_trdy && m_axis_tlast;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_found) begin
          grant_d = req_idx;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (frame_done) begin
          state_d  = StIdle;
          rr_ptr_d = wrap_idx(32'(grant_q) + 32'd1);
          if (frame_cnt_q[grant_q] != '1) begin
            frame_cnt_d[grant_q] = frame_cnt_q[grant_q] + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      frame_cnt_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_grant_idx = grant_q;
  assign o_busy      = (state_q == StXfer);

  always_comb begin
    o_frame_cnt = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      o_frame_cnt[i*CNT_WIDTH +: CNT_WIDTH] = frame_cnt_q[i];
    end
  end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Directed bench for tx_axis_arbiter: per-source beat queues drive the inputs and a
// scoreboard of expected MAC-side beats (with source id) is checked on every accepted beat.
module tb_tx_axis_arbiter;

  localparam int NS = 2;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_trdy;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_trdy;
  logic [0:0]       grant_idx;
  logic             busy;
  logic [NS*CW-1:0] frame_cnt;

  tx_axis_arbiter #(
    .NUM_SRC   (NS),
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .IDX_WIDTH (1),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_trdy  (s_trdy),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_trdy  (m_trdy),
    .o_grant_idx  (grant_idx),
    .o_busy       (busy),
    .o_frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t src_q [NS][$];
  beat_t exp_q [$];
  int    sent [NS];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  bp_mode = 1'b0;
  int    gap_src = 0;
  int    gap_at = 0;
  int    gap_left = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cnt(input int k);
    return 64'(frame_cnt[k*CW +: CW]);
  endfunction

  // Frames must be pushed in the order the arbiter is expected to grant them.
  task automatic push_frame(input int k, input int n, input int fid);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.src  = 2'(k);
      b.data = {8'(k), 8'(fid), 16'(i)};
      b.last = (i == n - 1);
      b.keep = b.last ? 4'($urandom_range(1, 15)) : 4'hF;
      src_q[k].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  // One cycle: drive at negedge, then evaluate the handshakes the coming posedge will take.
  task automatic step();
    logic  gapping;
    beat_t b;
    beat_t obs;
    @(negedge clk);
    gapping = 1'b0;
    for (int k = 0; k < NS; k++) begin
      s_tvalid[k] = 1'b0;
      s_tlast[k]  = 1'b0;
      s_tdata[k*DW +: DW] = '0;
      s_tkeep[k*KW +: KW] = '0;
      if (gap_left > 0 && k == gap_src && sent[k] == gap_at && src_q[k].size() > 0) begin
        gapping = 1'b1;
      end else if (src_q[k].size() > 0) begin
        b = src_q[k][0];
        s_tvalid[k] = 1'b1;
        s_tlast[k]  = b.last;
        s_tdata[k*DW +: DW] = b.data;
        s_tkeep[k*KW +: KW] = b.keep;
      end
    end
    if (gapping) gap_left--;
    m_trdy = bp_mode ? ~m_trdy : 1'b1;
    #1;
    if (gapping) begin
      chk("gap_tvalid", 64'(m_tvalid), 64'd0);
      chk("gap_grant", 64'(grant_idx), 64'(gap_src));
    end
    if (m_tvalid && m_trdy) begin
      obs = {2'(grant_idx), m_tdata, m_tkeep, m_tlast};
      if (exp_q.size() == 0) chk("unexpected_beat", 64'(m_tvalid), 64'd0);
      else chk("beat", 64'(obs), 64'(exp_q.pop_front()));
    end
    for (int k = 0; k < NS; k++) begin
      if (s_tvalid[k] && s_trdy[k]) begin
        void'(src_q[k].pop_front());
        sent[k]++;
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int c = 0;
    while ((exp_q.size() > 0 || src_q[0].size() > 0 || src_q[1].size() > 0) && c < max_cycles) begin
      step();
      c++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    step();
  endtask

  initial begin
    int base;
    int c;
    rst_n = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; m_trdy = 1'b1;
    for (int k = 0; k < NS; k++) sent[k] = 0;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_trdy", 64'(s_trdy), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    rst_n = 1'b1;

    // Idle for 20 cycles
    repeat (20) step();
    chk("idle_tvalid", 64'(m_tvalid), 64'd0);
    chk("idle_trdy", 64'(s_trdy), 64'd0);
    chk("idle_grant", 64'(grant_idx), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_cnt", 64'(frame_cnt), 64'd0);

    // Single source: src1, 16 beats; grant follows one cycle after tvalid
    push_frame(1, 16, 1);
    step();
    chk("arb_cycle_tvalid", 64'(m_tvalid), 64'd0);
    chk("arb_cycle_busy", 64'(busy), 64'd0);
    chk("arb_cycle_trdy", 64'(s_trdy), 64'd0);
    step();
    chk("grant_src1", 64'(grant_idx), 64'd1);
    chk("grant_busy", 64'(busy), 64'd1);
    chk("first_beat_valid", 64'(m_tvalid), 64'd1);
    drain(60);
    chk("single_cnt1", cnt(1), 64'd1);
    chk("single_cnt0", cnt(0), 64'd0);
    chk("single_busy", 64'(busy), 64'd0);

    // Contention: rr_ptr back at 0, so grants run 0,1,0,1,...
    for (int f = 0; f < 4; f++) begin
      push_frame(0, 4, 10 + f);
      push_frame(1, 4, 20 + f);
    end
    drain(100);
    chk("cont_cnt0", cnt(0), 64'd4);
    chk("cont_cnt1", cnt(1), 64'd5);

    // Backpressure on a 15-beat src0 frame; src1 must stay blocked throughout
    push_frame(0, 15, 30);
    push_frame(1, 2, 31);
    bp_mode = 1'b1;
    c = 0;
    while (src_q[0].size() > 0 && c < 80) begin
      step();
      chk("bp_src1_blocked", 64'(s_trdy[1]), 64'd0);
      c++;
    end
    chk("bp_src0_done", 64'(src_q[0].size()), 64'd0);
    drain(40);
    bp_mode = 1'b0;
    m_trdy = 1'b1;
    chk("bp_cnt0", cnt(0), 64'd5);
    chk("bp_cnt1", cnt(1), 64'd6);

    // Mid-frame gap of 3 cycles after 5 beats of src0 while src1 requests
    gap_src = 0;
    gap_at = sent[0] + 5;
    gap_left = 3;
    push_frame(0, 10, 40);
    push_frame(1, 4, 41);
    drain(60);
    chk("gap_consumed", 64'(gap_left), 64'd0);
    chk("gap_cnt0", cnt(0), 64'd6);
    chk("gap_cnt1", cnt(1), 64'd7);

    // Single-beat frame with src1's counter already at its maximum
    push_frame(1, 1, 50);
    drain(10);
    chk("sat_cnt1", cnt(1), 64'd7);
    chk("sat_cnt0", cnt(0), 64'd6);

    // Asynchronous reset at beat 7 of a src1 frame
    base = sent[1];
    push_frame(1, 16, 60);
    c = 0;
    while (sent[1] < base + 7 && c < 40) begin
      step();
      c++;
    end
    chk("rst_mid_reached", 64'(sent[1] - base), 64'd7);
    #1 rst_n = 1'b0;
    #1;
    chk("amid_tvalid", 64'(m_tvalid), 64'd0);
    chk("amid_trdy", 64'(s_trdy), 64'd0);
    chk("amid_busy", 64'(busy), 64'd0);
    chk("amid_cnt", 64'(frame_cnt), 64'd0);
    for (int k = 0; k < NS; k++) src_q[k].delete();
    exp_q.delete();
    @(negedge clk);
    s_tvalid = '0; s_tlast = '0;
    rst_n = 1'b1;
    push_frame(1, 3, 70);
    step();
    step();
    chk("post_rst_grant", 64'(grant_idx), 64'd1);
    drain(20);
    chk("post_rst_cnt1", cnt(1), 64'd1);
    chk("post_rst_cnt0", cnt(0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
